// File: rtl/botassium_mem_copy_master.sv
// botassium_mem_copy_master: Avalon-MM master copying a block of words inside one single-port on-chip memory
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   cmd_start/src/dst/len/abort     - command interface (start honoured only when busy=0)
//   busy, done, error, words_copied - status (done pulses once per accepted command)
//   address, byteenable, chipselect, write, writedata, readdata, waitrequest - Avalon-MM master port
module botassium_mem_copy_master #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 5000,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic [ADDR_W-1:0]     cmd_src,
  input  logic [ADDR_W-1:0]     cmd_dst,
  input  logic [ADDR_W:0]       cmd_len,
  input  logic                  cmd_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W:0]       words_copied,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W-1:0]     readdata,
  input  logic                  waitrequest
);
  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, FIN} state_t;
  localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);
  localparam logic [1:0] LAT = 2'(READ_LATENCY);
  state_t state;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [ADDR_W:0] remaining;
  logic [1:0] lat_cnt;
  logic abort_pending;
  logic range_bad;
  // ends are computed one bit wider than the length so the sum cannot overflow
  always_comb range_bad = ({2'b0, cmd_src} + {1'b0, cmd_len} > DEPTH_L) ||
                          ({2'b0, cmd_dst} + {1'b0, cmd_len} > DEPTH_L);
  always_comb byteenable = chipselect ? '1 : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      src_ptr       <= '0;
      dst_ptr       <= '0;
      remaining     <= '0;
      lat_cnt       <= '0;
      abort_pending <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_copied  <= '0;
      address       <= '0;
      chipselect    <= 1'b0;
      write         <= 1'b0;
      writedata     <= '0;
    end else begin
      done          <= 1'b0;
      abort_pending <= abort_pending | (cmd_abort & busy);
      case (state)
        IDLE, FIN: begin
          state         <= IDLE;
          abort_pending <= 1'b0;
          if (cmd_start) begin
            src_ptr      <= cmd_src;
            dst_ptr      <= cmd_dst;
            remaining    <= cmd_len;
            words_copied <= '0;
            error        <= 1'b0;
            if (cmd_len == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else if (range_bad) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              busy       <= 1'b1;
              chipselect <= 1'b1;
              write      <= 1'b0;
              address    <= cmd_src;
              state      <= RD;
            end
          end
        end
        RD: begin
          if (!waitrequest) begin
            chipselect <= 1'b0;
            lat_cnt    <= LAT;
            state      <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (lat_cnt == 2'd1) begin
            writedata  <= readdata;
            chipselect <= 1'b1;
            write      <= 1'b1;
            address    <= dst_ptr;
            state      <= WR;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        WR: begin
          if (!waitrequest) begin
            src_ptr      <= src_ptr + 1'b1;
            dst_ptr      <= dst_ptr + 1'b1;
            words_copied <= words_copied + 1'b1;
            remaining    <= remaining - 1'b1;
            write        <= 1'b0;
            // an abort seen on the accepting cycle also ends the copy at this boundary
            if (remaining == 1 || abort_pending || cmd_abort) begin
              chipselect <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= FIN;
            end else begin
              address <= src_ptr + 1'b1;
              state   <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_botassium_mem_copy_master.sv
// tb_botassium_mem_copy_master: directed bench for botassium_mem_copy_master against a latency-1 memory model
module tb_botassium_mem_copy_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_start = 1'b0;
  logic [12:0] cmd_src = '0;
  logic [12:0] cmd_dst = '0;
  logic [13:0] cmd_len = '0;
  logic cmd_abort = 1'b0;
  logic busy, done, error, chipselect, write;
  logic [13:0] words_copied;
  logic [12:0] address;
  logic [3:0] byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata = '0;
  logic waitrequest = 1'b0;
  logic [31:0] mem [0:8191];
  logic pl_en = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic rand_en = 1'b0;
  int cs_seen = 0;
  int stall_seen = 0;
  int stall_err = 0;
  int pass_n = 0;
  int total_n = 0;

  botassium_mem_copy_master dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .cmd_abort(cmd_abort), .busy(busy), .done(done), .error(error),
    .words_copied(words_copied), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (chipselect && !waitrequest) begin
      if (write) mem[address] <= writedata;
      else readdata <= mem[address];
    end
  end

  initial begin
    logic p_cs, p_wr, p_wait;
    logic [12:0] p_addr;
    logic [31:0] p_data;
    p_cs = 0; p_wr = 0; p_wait = 0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk);
      if (chipselect) cs_seen++;
      if (p_cs && p_wait) begin
        stall_seen++;
        if ({chipselect, write, address, writedata} !== {1'b1, p_wr, p_addr, p_data}) stall_err++;
      end
      p_cs = chipselect; p_wr = write; p_addr = address; p_data = writedata;
      waitrequest = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
      p_wait = waitrequest;
    end
  end

  task automatic fill(input int base, input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 13'(base + i); pl_data = seed + 32'(i);
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_cmd(input int src, input int dst, input int len, input int abort_at,
                         input int reset_at, output int done_k, output int busy_n, output int done_n);
    done_k = -1; busy_n = 0; done_n = 0;
    @(negedge clk);
    cmd_src = 13'(src); cmd_dst = 13'(dst); cmd_len = 14'(len); cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 2) break;
      cmd_abort = (k == abort_at);
      @(negedge clk);
    end
    cmd_abort = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total_n++;
    if ({busy, done, error, words_copied, address, byteenable, chipselect, write, writedata} !== '0)
      $display("FAIL reset_outputs got %h want 0", {busy, done, error, words_copied, address, byteenable, chipselect, write, writedata});
    else pass_n++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_copy;
    int dk, bn, dn, bad;
    fill(0, 4, 32'hA000_0000);
    run_cmd(0, 100, 4, 0, 0, dk, bn, dn);
    total_n++; if (dk !== 13) $display("FAIL copy_done_cycle got %0d want 13", dk); else pass_n++;
    total_n++; if (bn !== 12) $display("FAIL copy_busy_cycles got %0d want 12", bn); else pass_n++;
    total_n++; if (dn !== 1) $display("FAIL copy_done_pulses got %0d want 1", dn); else pass_n++;
    total_n++; if (words_copied !== 14'd4) $display("FAIL copy_words got %0d want 4", words_copied); else pass_n++;
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[100+i] !== 32'hA000_0000 + 32'(i)) bad++;
    total_n++; if (bad !== 0) $display("FAIL copy_data got %0d bad words want 0", bad); else pass_n++;
  endtask

  task automatic test_len_zero;
    int dk, bn, dn, cs0;
    cs0 = cs_seen;
    run_cmd(10, 20, 0, 0, 0, dk, bn, dn);
    total_n++; if (dk !== 1) $display("FAIL len0_done_cycle got %0d want 1", dk); else pass_n++;
    total_n++; if (cs_seen - cs0 !== 0) $display("FAIL len0_bus got %0d cycles want 0", cs_seen - cs0); else pass_n++;
    total_n++; if ({error, words_copied} !== 15'd0) $display("FAIL len0_status got %h want 0", {error, words_copied}); else pass_n++;
  endtask

  task automatic test_range_error;
    int dk, bn, dn, cs0;
    cs0 = cs_seen;
    run_cmd(4990, 0, 20, 0, 0, dk, bn, dn);
    total_n++; if (error !== 1'b1) $display("FAIL src_range_error got %b want 1", error); else pass_n++;
    total_n++; if (dk !== 1 || dn !== 1) $display("FAIL src_range_done got k=%0d n=%0d want k=1 n=1", dk, dn); else pass_n++;
    total_n++; if (cs_seen - cs0 !== 0) $display("FAIL src_range_bus got %0d want 0", cs_seen - cs0); else pass_n++;
    run_cmd(0, 4999, 2, 0, 0, dk, bn, dn);
    total_n++; if (error !== 1'b1 || bn !== 0) $display("FAIL dst_range_error got %b busy=%0d want 1 busy=0", error, bn); else pass_n++;
    fill(4999, 1, 32'hC0DE_0000);
    run_cmd(4999, 30, 1, 0, 0, dk, bn, dn);
    total_n++; if (error !== 1'b0) $display("FAIL error_clear got %b want 0", error); else pass_n++;
    total_n++; if (dk !== 4 || mem[30] !== 32'hC0DE_0000) $display("FAIL edge_copy got k=%0d d=%h want k=4 d=c0de0000", dk, mem[30]); else pass_n++;
  endtask

  task automatic test_stall;
    int dk, bn, dn, bad, st0;
    fill(200, 16, 32'h5500_0000);
    st0 = stall_seen;
    rand_en = 1'b1;
    run_cmd(200, 300, 16, 0, 0, dk, bn, dn);
    rand_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[300+i] !== 32'h5500_0000 + 32'(i)) bad++;
    total_n++; if (bad !== 0) $display("FAIL stall_data got %0d bad words want 0", bad); else pass_n++;
    total_n++; if (words_copied !== 14'd16) $display("FAIL stall_words got %0d want 16", words_copied); else pass_n++;
    total_n++; if (stall_err !== 0 || stall_seen == st0) $display("FAIL stall_stable got err=%0d stalls=%0d want err=0 stalls>0", stall_err, stall_seen - st0); else pass_n++;
  endtask

  task automatic test_abort;
    int dk, bn, dn;
    fill(400, 10, 32'h7700_0000);
    fill(500, 10, 32'hDEAD_0000);
    run_cmd(400, 500, 10, 7, 0, dk, bn, dn);
    total_n++; if (dk !== 10) $display("FAIL abort_done_cycle got %0d want 10", dk); else pass_n++;
    total_n++; if (words_copied !== 14'd3 || busy !== 1'b0) $display("FAIL abort_status got w=%0d busy=%b want w=3 busy=0", words_copied, busy); else pass_n++;
    total_n++; if (mem[502] !== 32'h7700_0002 || mem[503] !== 32'hDEAD_0003) $display("FAIL abort_data got %h %h want 77000002 dead0003", mem[502], mem[503]); else pass_n++;
  endtask

  task automatic test_reset_mid;
    int dk, bn, dn, bad;
    fill(600, 5, 32'h6600_0000);
    run_cmd(600, 700, 5, 0, 6, dk, bn, dn);
    total_n++; if ({chipselect, busy, done} !== 3'b000) $display("FAIL midreset_outputs got %b want 000", {chipselect, busy, done}); else pass_n++;
    run_cmd(600, 800, 5, 0, 0, dk, bn, dn);
    bad = 0;
    for (int i = 0; i < 5; i++) if (mem[800+i] !== 32'h6600_0000 + 32'(i)) bad++;
    total_n++; if (dk !== 16 || bad !== 0 || words_copied !== 14'd5) $display("FAIL midreset_recover got k=%0d bad=%0d w=%0d want k=16 bad=0 w=5", dk, bad, words_copied); else pass_n++;
  endtask

  task automatic test_overlap;
    int dk, bn, dn;
    fill(0, 4, 32'hB000_0000);
    run_cmd(0, 1, 3, 0, 0, dk, bn, dn);
    total_n++;
    if ({mem[1], mem[2], mem[3]} !== {3{32'hB000_0000}}) $display("FAIL overlap_data got %h %h %h want b0000000 x3", mem[1], mem[2], mem[3]);
    else pass_n++;
  endtask

  initial begin
    test_reset;
    test_copy;
    test_len_zero;
    test_range_error;
    test_stall;
    test_abort;
    test_reset_mid;
    test_overlap;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/botassium_mem_copy_master.md
Name: botassium_mem_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words from one word address to another inside the on-chip memory (2^13 words, 32-bit data, fixed read latency, single port).
- Sits between a command source (Nios CSR glue or a control FSM) and the memory's s1/s2 slave port.
- Issues one read, captures the data after the fixed latency, writes it back, and repeats until the length is exhausted. Reports done, error and progress.

Parameters:
- ADDR_W, 13, word-address width of the master port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 5000, number of valid words. Any command touching address >= DEPTH is rejected.
- READ_LATENCY, 1, cycles from read acceptance to valid readdata (1..3).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle command strobe. Honoured only when busy=0.
- cmd_src  in  ADDR_W  source start word address.
- cmd_dst  in  ADDR_W  destination start word address.
- cmd_len  in  ADDR_W+1  number of words to copy (0..DEPTH).
- cmd_abort  in  1  stop at the next word boundary.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of every accepted command (normal, abort, or error).
- error  out  1  held high after a rejected command; cleared by the next cmd_start.
- words_copied  out  ADDR_W+1  count of completed writes for the current or last command.
- address  out  ADDR_W  Avalon master address.
- byteenable  out  DATA_W/8  always all-ones while chipselect=1; 0 otherwise.
- chipselect  out  1  Avalon chipselect.
- write  out  1  Avalon write, qualified by chipselect.
- writedata  out  DATA_W  captured read word.
- readdata  in  DATA_W  Avalon readdata.
- waitrequest  in  1  slave stall. Tie to 0 for the on-chip memory.

Behaviour:
- Reset, and any cycle with reset=1 including mid-copy:
  - all outputs are 0 at the next edge; state goes to IDLE.
  - chipselect drops immediately. A partially copied block is left as is.
- States: IDLE, RD, RDWAIT, WR, FIN.
- IDLE: on cmd_start, latch src, dst and len, clear words_copied, clear error.
  - len=0: go to FIN, no bus activity.
  - src+len>DEPTH or dst+len>DEPTH: set error=1 and go to FIN, no bus activity.
  - otherwise: set busy=1 and go to RD.
- RD: chipselect=1, write=0, address=src_ptr. The state is held, with all master outputs stable, while waitrequest=1. When waitrequest=0, load the latency counter with READ_LATENCY and go to RDWAIT.
- RDWAIT: decrement the counter. On the cycle READ_LATENCY after acceptance, register readdata into writedata and go to WR. chipselect=0 in this state.
- WR: chipselect=1, write=1, address=dst_ptr, writedata held. On waitrequest=0:
  - increment src_ptr, dst_ptr and words_copied; decrement remaining.
  - remaining becomes 0, or abort is pending: go to FIN. Otherwise go to RD.
- FIN: done=1 for exactly one cycle, busy=0 from the same edge, return to IDLE.
- Abort:
  - cmd_abort in any active state sets abort_pending.
  - An accepted bus transaction always completes; the FSM exits only after WR is accepted.
  - cmd_abort in IDLE is ignored; abort_pending is cleared in IDLE.
- Throughput with waitrequest=0 is 2+READ_LATENCY cycles per word. With the start strobe at cycle t, done asserts at t+1+N*(2+READ_LATENCY).
- Copy direction is forward only. With overlapping regions where dst is in (src, src+len), source words are overwritten before they are read; this replication is the defined result.
- Pointers never wrap; the range check guarantees this.
- cmd_start while busy=1 is ignored, with no error.
- cmd_start and cmd_abort in the same IDLE cycle: the start is accepted and the abort is dropped.

Test Plan:
- Preload mem[0..3]=A0..A3, start src=0 dst=100 len=4, READ_LATENCY=1, waitrequest=0 -> mem[100..103]=A0..A3; done at t+13; words_copied=4; busy high for cycles t+1..t+12.
- len=0 -> done at t+1, chipselect never asserted, error=0, words_copied=0.
- src=4990 len=20 -> error=1, done one pulse, no bus cycle; the next valid start clears error.
- Random waitrequest (50%) during a 16-word copy -> address, write and writedata stable while stalled; destination correct; words_copied=16.
- Abort asserted during the third read of a len=10 copy -> exactly 3 words written, done pulse, words_copied=3, busy=0.
- Reset asserted in WR of word 2 -> next cycle chipselect=0, busy=0, done=0; a new start afterwards completes normally.
- Overlap src=0 dst=1 len=3 with mem[0..3]=B0..B3 -> mem[1..3]=B0,B0,B0.
